// File: rtl/jtframe_cen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } lock_state_e;

  localparam int SYNC_DEPTH = 2;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/jtframe_cen_acc.sv
// One fractional enable channel: accumulator, active/pending ratio, cenb phase
// and the optional pulse counter (enabled by JTFRAME_CEN_STATS_EN).
module jtframe_cen_acc
  import jtframe_cen_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEF_N = 1,
  parameter int DEF_M = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               clr,
  input  logic               we,
  input  logic [W-1:0]       wr_n,
  input  logic [W-1:0]       wr_m,
  output logic               cen,
  output logic               cenb,
  output logic               busy
`ifdef JTFRAME_CEN_STATS_EN
  ,
  output logic [STATS_W-1:0] cnt
`endif
);

  logic [W-1:0] act_n, act_m, pend_n, pend_m, acc;
  logic [W:0]   sum, half, diff;
  logic         wrap, step;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, act_n};
    half = {2'b0, act_m[W-1:1]};
    diff = sum - {1'b0, act_m};
    wrap = sum >= {1'b0, act_m};
    step = run_en && (act_n != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_n  <= W'(DEF_N);
      act_m  <= W'(DEF_M);
      pend_n <= W'(DEF_N);
      pend_m <= W'(DEF_M);
      acc    <= '0;
      busy   <= 1'b0;
      cen    <= 1'b0;
      cenb   <= 1'b0;
    end else begin
      cen  <= 1'b0;
      cenb <= 1'b0;
      if (clr) begin
        acc <= '0;
      end else if (step) begin
        if (wrap) begin
          acc <= diff[W-1:0];
          cen <= 1'b1;
        end else begin
          acc  <= sum[W-1:0];
          cenb <= ({1'b0, acc} < half) && (half <= sum);
        end
      end
      // Pending ratio swaps in at a wrap, or at once when nothing is counting.
      if (busy && !clr) begin
        if (!step) begin
          act_n <= pend_n;
          act_m <= pend_m;
          acc   <= '0;
          busy  <= 1'b0;
        end else if (wrap) begin
          act_n <= pend_n;
          act_m <= pend_m;
          busy  <= 1'b0;
        end
      end
      // A write landing on the apply edge wins and stays pending.
      if (we) begin
        pend_n <= wr_n;
        pend_m <= wr_m;
        busy   <= 1'b1;
      end
    end
  end

`ifdef JTFRAME_CEN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + STATS_W'(cen);
  end
`endif

endmodule

// File: rtl/jtframe_cen_gen.sv
// Multi-channel fractional cen/cenb generator gated by PLL lock.
// Define JTFRAME_CEN_STATS_EN to add per-channel cen pulse counters on cen_cnt.
module jtframe_cen_gen
  import jtframe_cen_pkg::*;
#(
  parameter  int CH        = 4,
  parameter  int W         = 10,
  parameter  int LOCK_WAIT = 1024,
  parameter  int DEF_N     = 1,
  parameter  int DEF_M     = 2,
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               cfg_we,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [W-1:0]       cfg_n,
  input  logic [W-1:0]       cfg_m,
  output logic               cfg_err,
  output logic [CH-1:0]      cfg_busy,
  output logic               run,
  output logic [CH-1:0]      cen,
  output logic [CH-1:0]      cenb,
  output logic [STATS_W-1:0] cen_cnt
);

  localparam int SCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  logic [SYNC_DEPTH-1:0] sync;
  logic                  lock_s;
  lock_state_e           state, next_state;
  logic [SCW-1:0]        settle;
  logic                  run_en, clr, bad, ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_DEPTH-2:0], pll_locked};
  end

  assign lock_s = sync[SYNC_DEPTH-1];

  // NOTE: next_state takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      WAIT:    if (lock_s) next_state = SETTLE;
      SETTLE:  if (!lock_s) next_state = WAIT;
               else if (settle == SCW'(LOCK_WAIT - 1)) next_state = RUN;
      RUN:     if (!lock_s) next_state = WAIT;
      default: next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT;
      settle <= '0;
      run    <= 1'b0;
    end else begin
      state  <= next_state;
      run    <= (next_state == RUN);
      settle <= (state == SETTLE && next_state == SETTLE) ? settle + 1'b1 : '0;
    end
  end

  // Channels count only while lock is still seen; the edge that drops back
  // to WAIT clears accumulators instead of producing a last strobe.
  assign run_en = (state == RUN) && lock_s;
  assign clr    = (state != WAIT) && !lock_s;

  always_comb begin
    bad = (cfg_m == '0) || (cfg_n > cfg_m) || (32'(cfg_ch) >= CH);
    ok  = cfg_we && !bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && bad;
  end

`ifdef JTFRAME_CEN_STATS_EN
  logic [STATS_W-1:0] cnt_arr [CH];
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jtframe_cen_acc #(
      .W     (W),
      .DEF_N (DEF_N),
      .DEF_M (DEF_M)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_en (run_en),
      .clr    (clr),
      .we     (ok && (32'(cfg_ch) == i)),
      .wr_n   (cfg_n),
      .wr_m   (cfg_m),
      .cen    (cen[i]),
      .cenb   (cenb[i]),
      .busy   (cfg_busy[i])
`ifdef JTFRAME_CEN_STATS_EN
      ,
      .cnt    (cnt_arr[i])
`endif
    );
  end

`ifdef JTFRAME_CEN_STATS_EN
  // NOTE: the counter array is reset explicitly; these are a few flops per
  // channel, not a RAM, so an async clear costs nothing and keeps counts sane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cen_cnt <= '0;
    else if (32'(cfg_ch) < CH)  cen_cnt <= cnt_arr[cfg_ch];
    else                        cen_cnt <= '0;
  end
`else
  assign cen_cnt = '0;
`endif

endmodule

// File: tb/tb_jtframe_cen_gen.sv
// Randomised bench for jtframe_cen_gen against a cycle-level behavioural model.
module tb_jtframe_cen_gen;

  localparam int CH = 3;
  localparam int W  = 10;
  localparam int LW = 16;
`ifdef JTFRAME_CEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_n, cfg_m;
  logic          cfg_err;
  logic [CH-1:0] cfg_busy, cen, cenb;
  logic          run;
  logic [15:0]   cen_cnt;

  jtframe_cen_gen #(.CH(CH), .W(W), .LOCK_WAIT(LW), .DEF_N(1), .DEF_M(2)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_err(cfg_err),
    .cfg_busy(cfg_busy), .run(run), .cen(cen), .cenb(cenb), .cen_cnt(cen_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: lock is "run" once the twice-delayed lock input has been
  // seen high on more than LW consecutive edges; channels follow the ratio rules.
  int lq[$];
  int streak;
  int m_run, m_err, m_cen_cnt;
  int m_n[CH], m_m[CH], m_pn[CH], m_pm[CH], m_busy[CH], m_acc[CH];
  int m_cen[CH], m_cenb[CH], m_cnt[CH];

  task automatic model_reset();
    lq = {0, 0};
    streak = 0; m_run = 0; m_err = 0; m_cen_cnt = 0;
    for (int c = 0; c < CH; c++) begin
      m_n[c] = 1; m_m[c] = 2; m_pn[c] = 1; m_pm[c] = 2;
      m_busy[c] = 0; m_acc[c] = 0; m_cen[c] = 0; m_cenb[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_tick();
    int ls, running, clr, bad, s, wr, active;
    ls = lq.pop_front();
    lq.push_back(int'(pll_locked));
    running = (streak >= LW + 1) && ls;
    clr     = (streak > 0) && !ls;
    streak  = ls ? ((streak > LW + 1) ? streak : streak + 1) : 0;
    m_run   = (streak >= LW + 1);
    bad     = (cfg_m == 0) || (cfg_n > cfg_m) || (int'(cfg_ch) >= CH);
    m_err   = cfg_we && bad;
    m_cen_cnt = (STATS && int'(cfg_ch) < CH) ? m_cnt[cfg_ch] : 0;
    for (int c = 0; c < CH; c++) begin
      if (STATS) m_cnt[c] = (m_cnt[c] + m_cen[c]) % 65536;
      active = running && (m_n[c] != 0);
      wr = 0;
      m_cenb[c] = 0;
      if (clr) m_acc[c] = 0;
      else if (active) begin
        s = m_acc[c] + m_n[c];
        if (s >= m_m[c]) begin
          wr = 1;
          s = s - m_m[c];
        end else begin
          m_cenb[c] = (m_acc[c] < m_m[c] / 2) && (m_m[c] / 2 <= s);
        end
        m_acc[c] = s;
      end
      m_cen[c] = wr;
      if (m_busy[c] && !clr && (!active || wr)) begin
        m_n[c] = m_pn[c]; m_m[c] = m_pm[c]; m_busy[c] = 0;
        if (!active) m_acc[c] = 0;
      end
      if (cfg_we && !bad && int'(cfg_ch) == c) begin
        m_pn[c] = int'(cfg_n); m_pm[c] = int'(cfg_m); m_busy[c] = 1;
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] e_cen, e_cenb, e_busy;
    @(posedge clk);
    model_tick();
    #1;
    for (int c = 0; c < CH; c++) begin
      e_cen[c] = m_cen[c][0]; e_cenb[c] = m_cenb[c][0]; e_busy[c] = m_busy[c][0];
    end
    check("run", run, m_run);
    check("cen", cen, e_cen);
    check("cenb", cenb, e_cenb);
    check("cfg_busy", cfg_busy, e_busy);
    check("cfg_err", cfg_err, m_err);
    check("cen_cnt", cen_cnt, m_cen_cnt);
  endtask

  task automatic write_cfg(input int ch, input int n, input int m);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_n = W'(n); cfg_m = W'(m);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int k = 0;
    while (!run && k < 200) begin step(); k++; end
    if (!run) check({tag, "_timeout"}, run, 1);
  endtask

  task automatic wait_idle(input int ch, input string tag);
    int k = 0;
    while (cfg_busy[ch] && k < 100) begin step(); k++; end
    if (cfg_busy[ch]) check({tag, "_timeout"}, cfg_busy[ch], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, cntb, lat, gap, seen_low, drop;
    rst_n = 1'b0; pll_locked = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_n = '0; cfg_m = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Lock latency from reset with lock already high
    lat = 0;
    while (!run && lat < 100) begin step(); lat++; end
    check("run_latency", lat, LW + 3);

    // Default 1/2 ratio on every channel
    cnt = 0;
    repeat (20) begin step(); cnt += int'(cen[0]) + int'(cen[2]); end
    check("default_rate", cnt, 20);

    // 3/8 ratio over 800 cycles
    write_cfg(0, 3, 8);
    wait_idle(0, "ratio_apply");
    cnt = 0; cntb = 0;
    repeat (800) begin step(); cnt += int'(cen[0]); cntb += int'(cenb[0]); end
    check("ratio_cen", cnt, 300);
    check("ratio_cenb", cntb, 300);

    // Glitch-free ratio change mid-period
    write_cfg(1, 1, 10);
    wait_idle(1, "slow_apply");
    repeat (3) step();
    write_cfg(1, 1, 4);
    check("pending", cfg_busy[1], 1);
    gap = 0;
    while (!cen[1] && gap < 20) begin step(); gap++; end
    check("old_period_done", cen[1], 1);
    check("busy_drop", cfg_busy[1], 0);
    repeat (2) begin
      gap = 0;
      do begin step(); gap++; end while (!cen[1] && gap < 20);
      check("new_period", gap, 4);
    end

    // Rejected writes
    write_cfg(0, 5, 0);
    check("rej_m0", cfg_err, 1);
    write_cfg(0, 5, 4);
    check("rej_n_gt_m", cfg_err, 1);
    write_cfg(3, 1, 2);
    check("rej_ch", cfg_err, 1);
    check("rej_busy", cfg_busy, 0);

    // Randomised writes and lock glitches
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        pll_locked = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        pll_locked = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        int m = $urandom_range(0, 12);
        write_cfg($urandom_range(0, 3), $urandom_range(0, m + 1), m);
      end else begin
        step();
      end
    end

    // Single-cycle lock loss
    pll_locked = 1'b1;
    wait_run("relock_pre");
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    drop = 1;
    while (run && drop < 10) begin step(); drop++; end
    check("loss_latency", drop, 3);
    check("loss_cen", cen, 0);
    cnt = drop - 1; seen_low = 1;
    while (cnt < 100) begin
      step(); cnt++;
      if (seen_low && run) break;
    end
    check("relock_latency", cnt, LW + 3);

    // Asynchronous reset mid-run with a write pending
    write_cfg(2, 1, 12);
    #3 rst_n = 1'b0;
    #1;
    check("rst_run", run, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_cen", cen, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Pulse statistics on channel 2
    write_cfg(2, 1, 4);
    wait_run("stats_run");
    repeat (402) step();
    check("stats_cnt", cen_cnt, STATS ? 100 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_cen_gen.md
# jtframe_cen_gen

Multi-channel fractional clock-enable generator for the system clock domain. It sits directly downstream of the core PLL wrapper and turns the PLL output into per-subsystem `cen`/`cenb` strobes at runtime-programmable ratios. It replaces one fixed PLL per target frequency, and keeps all enables silent until PLL lock has been stable for a settle period.

## Interface
- `CH`, 4: number of enable channels (1–8).
- `W`, 10: width of the numerator and denominator per channel.
- `LOCK_WAIT`, 1024: cycles that `pll_locked` must stay high before the strobes start.
- `DEF_N`, 1: reset numerator for every channel.
- `DEF_M`, 2: reset denominator for every channel.
- `clk`  in  1  system clock (PLL output).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock; asynchronous; passes through a 2-flop synchroniser before use.
- `cfg_we`  in  1  one-cycle configuration write strobe.
- `cfg_ch`  in  $clog2(CH) (min 1)  target channel.
- `cfg_n`  in  W  numerator.
- `cfg_m`  in  W  denominator.
- `cfg_err`  out  1  one-cycle pulse: last write was rejected.
- `cfg_busy`  out  CH  per channel, a write is pending.
- `run`  out  1  high while strobes are active.
- `cen`  out  CH  one-cycle enable, average rate f_clk·n/m.
- `cenb`  out  CH  half-phase enable.
- `cen_cnt`  out  16  pulse count for channel `cfg_ch`.

## Operation
- Lock FSM states:
  - `WAIT`: waits for synchronised lock.
  - `SETTLE`: counts to LOCK_WAIT-1 while lock stays high, then goes to `RUN`.
  - `RUN`: `run`=1.
- Lock loss in `SETTLE` or `RUN` returns to `WAIT` on the next cycle. On that transition:
  - all accumulators clear to 0;
  - `cen`/`cenb` go low;
  - active n/m values are kept;
  - pending writes are kept.
- Per channel, in `RUN`:
  - sum = acc + n, computed in W+1 bits; h = m>>1.
  - If sum ≥ m: acc ← sum−m and `cen` ← 1.
  - Otherwise: acc ← sum.
  - `cenb` ← 1 when there is no wrap and acc < h ≤ sum.
- A channel with n=0 is stopped: acc is held and no strobes are produced.
- Write validation: writes with m=0, n>m, or cfg_ch ≥ CH are rejected. A rejected write pulses `cfg_err` and changes no state.
- Accepted writes go to the channel's pending register and set `cfg_busy[ch]`.
  - Pending values become active on the channel's next wrap, in the same edge that produces `cen`.
  - If the channel is stopped or the FSM is not in `RUN`, pending values become active on the next edge and acc clears to 0.
- A second write while pending overwrites the pending values.
- A write in the same cycle as a wrap: the wrap uses the old values. The new values stay pending until the following wrap.
- `cenb` is only guaranteed one per period when n ≤ m/2. For larger n it may be omitted in some periods; this is not an error.

## Timing
- All outputs are registered. Reset values:
  - `cen`, `cenb`, `run`, `cfg_err`, `cfg_busy`, `cen_cnt` = 0;
  - acc = 0;
  - n/m = DEF_N/DEF_M;
  - FSM in `WAIT`.
- Lock latency: `pll_locked` rising to `run` high = 2 (synchroniser) + LOCK_WAIT + 1 cycles.
- Lock loss: `pll_locked` falling to `run`/strobes low = 3 cycles.
- Accumulation starts in the first cycle with `run`=1 (cycle R).
  - With n=1, m=4 the first `cen` is at R+4, then every 4 cycles.
- `cfg_err` is high in the cycle after `cfg_we`.
- `cfg_busy` rises in the cycle after `cfg_we` and falls in the same cycle the new values are active.
- Asserting `rst_n` low mid-operation clears everything immediately (asynchronous). Deassertion is synchronised externally.

## Configuration
- `JTFRAME_CEN_STATS_EN` defined:
  - each channel has a 16-bit wrapping counter of `cen` pulses, cleared on reset only;
  - `cen_cnt` shows the count for `cfg_ch`, registered, 1 cycle latency.
- Undefined: `cen_cnt` is tied to 0 and no counters are synthesised.

## Structure
- Package `jtframe_cen_pkg`:
  - lock FSM state enum (`WAIT`, `SETTLE`, `RUN`);
  - synchroniser depth constant (2);
  - stats width constant (16).
- Sub-module `jtframe_cen_acc`: one channel, covering accumulator, active/pending n/m, `cenb` logic and the optional stats counter. Instantiated CH times in a generate loop.
- Top level holds the synchroniser, lock FSM, settle counter, write decode/validation and `cen_cnt` mux.

## Test plan
- Reset defaults: LOCK_WAIT=16, locked=1 from reset → `run` rises 19 cycles after reset release; each channel (1/2) gives `cen` every 2 cycles.
- Ratio: ch0 n=3, m=8 → exactly 3 `cen` per 8 cycles across 800 cycles (300 pulses); `cenb` count 300.
- Glitch-free update: ch1 running n=1, m=10; write n=1, m=4 mid-period → old period completes, `cfg_busy[1]` drops at that `cen`, then period 4.
- Rejects: writes m=0; n=5, m=4; cfg_ch=CH → `cfg_err` pulse each time, `cfg_busy` and strobes unchanged.
- Lock loss: drop `pll_locked` for 1 cycle during `RUN` → strobes stop 3 cycles later, accumulators read 0, `run` returns after 2+LOCK_WAIT+1 cycles.
- Stats (with macro): ch2 n=1, m=4 for 400 cycles of `RUN` → `cen_cnt` = 100 with cfg_ch=2; without macro, always 0.
